score_display_ctrl: RTL and testbench
=====================================

# score_display_ctrl

- Sequential controller that converts a binary game score into per-digit BCD nibbles for the bank of 7-segment decoder instances (`segDisplay`) in the GENIUS display path.
- Conversion is iterative double-dabble: one bit per clock, started by a load strobe, ending with a one-cycle done pulse.
- Also handles saturation and blanking. Blanking uses the decoder's out-of-range code 4'hF, which the decoder renders as all segments off.

## Interface

Parameters:
- `DIGITS`, default 2: number of BCD digits driven; legal range 1–4.
- `BIN_W`, default 7: width of the binary score input; legal range 1–14.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `load` input 1: start conversion of `value`; accepted only when `busy`=0.
- `value` input BIN_W: unsigned binary score, sampled on the accepting edge.
- `blank` input 1: force every digit dark while high.
- `busy` output 1: conversion in progress.
- `done` output 1: one-cycle pulse marking the cycle in which new `bcd` is first visible.
- `ovf` output 1: the last converted value exceeded 10^DIGITS−1.
- `bcd` output 4*DIGITS: digit nibbles, least-significant digit in [3:0]; each nibble feeds one decoder `b` input.

## Operation

State machine:
- States are IDLE, CONV and LATCH.
- IDLE → CONV on `load`=1. On that edge:
  - shift register ← `value`;
  - BCD accumulator ← 0;
  - bit counter ← 0;
  - pending overflow flag ← (`value` > 10^DIGITS−1).
- CONV, each edge:
  - first, every accumulator nibble ≥5 gets +3;
  - then {accumulator, shift register} shifts left by one;
  - counter increments.
- CONV → LATCH after exactly BIN_W CONV edges.
- LATCH → IDLE unconditionally. On that edge:
  - result register ← accumulator, or all nibbles 4'h9 if the pending overflow flag is set;
  - `ovf` ← pending overflow flag.
- Accumulator width is 4*DIGITS+4 bits. Bits above 4*DIGITS are discarded; correct results above the digit range are guaranteed by the overflow saturation.

Handshake and sequencing:
- `busy`=1 in CONV and LATCH.
- `load` while `busy`=1 is ignored; it is not queued.
- `load` in IDLE on the same edge as `rst` is ignored; reset wins.

Output stage:
- `bcd` is a register recomputed every cycle from the held result register.
- `blank`=1 → every nibble is 4'hF.
- Otherwise, nibbles follow the result register, subject to the leading-zero option in Configuration.
- The held result survives any number of `blank` toggles.

Reset:
- Synchronous `rst` aborts any conversion: state → IDLE, no `done`, result register ← 0.
- Output values after reset:
  - `busy`=0;
  - `done`=0;
  - `ovf`=0;
  - `bcd`=all 4'hF (display dark until the first conversion).

## Timing

- Let edge E be the edge where `load`=1 is sampled in IDLE.
- `busy` rises after E.
- Edges E+1 … E+BIN_W are the CONV iterations.
- Edge E+BIN_W+1 is the LATCH edge, which updates the result register and `ovf`.
- Edge E+BIN_W+2 updates `bcd`. `done`=1 for exactly the cycle following E+BIN_W+2.
- `busy` falls after E+BIN_W+1. A new `load` may therefore be accepted at edge E+BIN_W+2 at the earliest, the same edge that registers the previous result to `bcd`.
- Total load-to-display latency is BIN_W+2 edges; with defaults, `bcd` is valid 9 cycles after E.
- `blank` latency is one edge, in both assertion and release.

## Configuration

- Macro: `SCORE_DISPLAY_LZB_EN`, which enables leading-zero blanking.
- Defined: scanning from the most-significant digit, each nibble that is 0 and has only zero nibbles above it outputs 4'hF. Digit 0 is never blanked, so a value of 0 shows a single "0".
- Undefined: all DIGITS nibbles always show their decimal value, zeros included.
- Either way, `blank`=1 overrides.

## Test plan

Defaults DIGITS=2, BIN_W=7, macro undefined unless stated:
- Reset, then idle → `bcd`=8'hFF, `busy`=0, `done`=0, `ovf`=0.
- `load` with `value`=42 at edge E:
  - `busy` high for 8 cycles;
  - `bcd`=8'h42 after E+9;
  - `done` high for exactly one cycle;
  - `ovf`=0.
- `value`=5 → `bcd`=8'h05. With macro defined → 8'hF5. Also with macro defined: `value`=0 → 8'hF0, and `value`=90 → 8'h90.
- `value`=120 → `bcd`=8'h99 and `ovf`=1. A following load of `value`=7 clears `ovf` and gives `bcd`=8'h07.
- Back-to-back loads:
  - `load`=1 with `value`=33, then a second `load` with `value`=11 pulsed during `busy` → ignored, result 8'h33.
  - A third `load` with `value`=11 at edge E+9 (first edge with `busy`=0) → accepted, 8'h11 follows.
- Mid-conversion reset and blanking:
  - `rst` asserted mid-CONV → no `done`, `bcd`=8'hFF.
  - After a conversion to 8'h42, toggling `blank` → 8'hFF one edge after assertion, 8'h42 one edge after release.

Source files
------------

// File: rtl/score_display_ctrl.sv
// Iterative double-dabble score-to-BCD converter with saturation and blanking for 7-seg decoders.
// Optional leading-zero blanking is enabled by defining SCORE_DISPLAY_LZB_EN.
module score_display_ctrl #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIN_W-1:0]      value,
    input  logic                  blank,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd
);

    function automatic int unsigned max_score(input int unsigned d);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < d; i++) r = r * 10;
        return r - 1;
    endfunction

    localparam int unsigned OutW   = 4 * DIGITS;
    localparam int unsigned AccW   = OutW + 4;
    localparam int unsigned CntW   = $clog2(BIN_W + 1);
    localparam int unsigned MaxVal = max_score(DIGITS);

    typedef enum logic [1:0] {StIdle, StConv, StLatch} state_e;

    state_e            state_q;
    logic [BIN_W-1:0]  sr_q;
    logic [AccW-1:0]   acc_q;
    logic [CntW-1:0]   cnt_q;
    logic              pend_ovf_q;
    logic [OutW-1:0]   res_q;
    logic              res_vld_q;
    logic              latched_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;
    logic [OutW-1:0]   bcd_q;

    logic [AccW-1:0]   acc_adj;
    logic [AccW-1:0]   acc_shift;
    logic [OutW-1:0]   disp_d;

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i <= int'(DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        // Top bit of the adjusted accumulator falls off; saturation covers that range.
        acc_shift = AccW'({acc_adj, sr_q[BIN_W-1]});
    end

`ifdef SCORE_DISPLAY_LZB_EN
    logic lead;
`endif

    always_comb begin
        disp_d = {DIGITS{4'hF}};
`ifdef SCORE_DISPLAY_LZB_EN
        lead = 1'b1;
`endif
        if (!blank && res_vld_q) begin
            disp_d = res_q;
`ifdef SCORE_DISPLAY_LZB_EN
            for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
                if (lead && res_q[4*i +: 4] == 4'h0) disp_d[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sr_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            pend_ovf_q <= 1'b0;
            res_q      <= '0;
            res_vld_q  <= 1'b0;
            latched_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= {DIGITS{4'hF}};
        end else begin
            bcd_q     <= disp_d;
            done_q    <= latched_q;
            latched_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        sr_q       <= value;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        pend_ovf_q <= 32'(value) > MaxVal;
                        busy_q     <= 1'b1;
                        state_q    <= StConv;
                    end
                end
                StConv: begin
                    acc_q <= acc_shift;
                    sr_q  <= sr_q << 1;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(BIN_W - 1)) state_q <= StLatch;
                end
                StLatch: begin
                    res_q     <= pend_ovf_q ? {DIGITS{4'h9}} : acc_q[OutW-1:0];
                    ovf_q     <= pend_ovf_q;
                    res_vld_q <= 1'b1;
                    latched_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed, table-driven bench for score_display_ctrl at DIGITS=2, BIN_W=7.
// Expectations follow SCORE_DISPLAY_LZB_EN when the bench is built with it defined.
module tb_score_display_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [6:0] value;
    logic       blank;
    logic       busy;
    logic       done;
    logic       ovf;
    logic [7:0] bcd;

    int checks = 0;
    int passed = 0;

    score_display_ctrl #(.DIGITS(2), .BIN_W(7)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (value),
        .blank (blank),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] value;
        logic [7:0] exp_bcd;
        logic       exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load v at edge E and observe E..E+11; returns result sampled after E+9.
    task automatic convert(input logic [6:0] v, output logic [7:0] got_bcd,
                           output logic got_ovf, output int busy_cnt, output int done_cnt,
                           output logic done_at9);
        busy_cnt = 0;
        done_cnt = 0;
        done_at9 = 1'b0;
        got_bcd  = '0;
        got_ovf  = 1'b0;
        load  = 1'b1;
        value = v;
        tick();
        load = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (k == 9) begin
                got_bcd  = bcd;
                got_ovf  = ovf;
                done_at9 = done;
            end
        end
    endtask

    vec_t       vecs[10];
    logic [7:0] g_bcd;
    logic       g_ovf;
    logic       g_d9;
    int         bc;
    int         dc;
    int         seen_done;

    initial begin
        vecs[0] = '{7'd42,  8'h42, 1'b0};
        vecs[1] = '{7'd90,  8'h90, 1'b0};
        vecs[2] = '{7'd99,  8'h99, 1'b0};
        vecs[3] = '{7'd100, 8'h99, 1'b1};
        vecs[4] = '{7'd120, 8'h99, 1'b1};
`ifdef SCORE_DISPLAY_LZB_EN
        vecs[5] = '{7'd7,   8'hF7, 1'b0};
        vecs[6] = '{7'd5,   8'hF5, 1'b0};
        vecs[7] = '{7'd0,   8'hF0, 1'b0};
`else
        vecs[5] = '{7'd7,   8'h07, 1'b0};
        vecs[6] = '{7'd5,   8'h05, 1'b0};
        vecs[7] = '{7'd0,   8'h00, 1'b0};
`endif
        vecs[8] = '{7'd127, 8'h99, 1'b1};
        vecs[9] = '{7'd10,  8'h10, 1'b0};

        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        blank = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("reset_bcd",  32'(bcd),  32'hFF);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ovf",  32'(ovf),  32'd0);

        foreach (vecs[i]) begin
            convert(vecs[i].value, g_bcd, g_ovf, bc, dc, g_d9);
            chk($sformatf("v%0d_bcd", vecs[i].value),  32'(g_bcd), 32'(vecs[i].exp_bcd));
            chk($sformatf("v%0d_ovf", vecs[i].value),  32'(g_ovf), 32'(vecs[i].exp_ovf));
            chk($sformatf("v%0d_busy_cycles", vecs[i].value), 32'(bc), 32'd8);
            chk($sformatf("v%0d_done_cycles", vecs[i].value), 32'(dc), 32'd1);
            chk($sformatf("v%0d_done_at9", vecs[i].value), 32'(g_d9), 32'd1);
        end

        // Load during busy is dropped; a load at E+9 is accepted.
        load  = 1'b1;
        value = 7'd33;
        tick();                       // E
        load = 1'b0;
        tick(); tick(); tick();       // E+3
        load  = 1'b1;
        value = 7'd11;
        tick();                       // E+4, ignored
        load = 1'b0;
        tick(); tick(); tick(); tick(); // E+8
        chk("b2b_idle_before_e9", 32'(busy), 32'd0);
        load  = 1'b1;
        value = 7'd11;
        tick();                       // E+9
        load = 1'b0;
        chk("b2b_first_bcd",  32'(bcd),  32'h33);
        chk("b2b_first_done", 32'(done), 32'd1);
        chk("b2b_third_busy", 32'(busy), 32'd1);
        repeat (9) tick();
        chk("b2b_third_bcd", 32'(bcd), 32'h11);

        // Reset mid-conversion aborts without done and darkens the display.
        load  = 1'b1;
        value = 7'd42;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_bcd",  32'(bcd),  32'hFF);
        seen_done = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) seen_done++;
        end
        chk("midrst_no_done", 32'(seen_done), 32'd0);
        chk("midrst_bcd_hold", 32'(bcd), 32'hFF);

        // Reset wins over a simultaneous load.
        rst   = 1'b1;
        load  = 1'b1;
        value = 7'd42;
        tick();
        rst  = 1'b0;
        load = 1'b0;
        tick();
        chk("rst_load_busy", 32'(busy), 32'd0);

        // Blank toggles with one-edge latency and the result is held.
        convert(7'd42, g_bcd, g_ovf, bc, dc, g_d9);
        chk("blank_pre", 32'(bcd), 32'h42);
        blank = 1'b1;
        tick();
        chk("blank_on", 32'(bcd), 32'hFF);
        tick();
        blank = 1'b0;
        tick();
        chk("blank_off", 32'(bcd), 32'h42);
        blank = 1'b1;
        tick();
        blank = 1'b0;
        tick();
        chk("blank_retoggle", 32'(bcd), 32'h42);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
